// File: rtl/arp_tx_if.sv
// ARP transmit word stream: 32-bit payload words under valid/ready.
interface arp_tx_if;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_last;

    modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
    modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/arp_tx_sched.sv
// ARP transmit scheduler: round-robin between request and reply sources,
// serialises the 7-word ARP payload and aborts frames stalled too long.
module arp_tx_sched #(
    parameter logic [15:0] HW_TYPE    = 16'h0001,
    parameter logic [15:0] PROTO_TYPE = 16'h0800,
    parameter logic [7:0]  HW_LEN     = 8'd6,
    parameter logic [7:0]  PRO_LEN    = 8'd4,
    parameter int unsigned STALL_MAX  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] local_mac,
    input  logic [31:0] local_ip,
    input  logic        req_valid,
    input  logic [31:0] req_target_ip,
    output logic        req_ready,
    input  logic        rep_valid,
    input  logic [47:0] rep_target_mac,
    input  logic [31:0] rep_target_ip,
    output logic        rep_ready,
    arp_tx_if.master    tx,
    output logic        busy,
    output logic        grant_src,
    output logic        done,
    output logic        abort
);
    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = $clog2(STALL_MAX + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(6);
    localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(STALL_MAX - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic               grant_q, grant_d;
    logic [47:0]        smac_q, smac_d;
    logic [31:0]        sip_q, sip_d;
    logic [47:0]        tmac_q, tmac_d;
    logic [31:0]        tip_q, tip_d;
    logic               done_q, done_d;
    logic               abort_q, abort_d;
    logic [15:0]        opcode;
    logic [31:0]        word;
    logic               sending;

    // State and latched frame fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            stall_q <= '0;
            grant_q <= 1'b0;
            smac_q  <= '0;
            sip_q   <= '0;
            tmac_q  <= '0;
            tip_q   <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stall_q <= stall_d;
            grant_q <= grant_d;
            smac_q  <= smac_d;
            sip_q   <= sip_d;
            tmac_q  <= tmac_d;
            tip_q   <= tip_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    // Arbitration, word sequencing and stall watchdog.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        stall_d   = stall_q;
        grant_d   = grant_q;
        smac_d    = smac_q;
        sip_d     = sip_q;
        tmac_d    = tmac_q;
        tip_d     = tip_q;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        req_ready = 1'b0;
        rep_ready = 1'b0;
        case (state_q)
            IDLE: begin
                idx_d   = '0;
                stall_d = '0;
                // On a tie the source that did not win last time goes next.
                if (req_valid && rep_valid) begin
                    rep_ready = ~grant_q;
                    req_ready = grant_q;
                end else begin
                    req_ready = req_valid;
                    rep_ready = rep_valid;
                end
                if ((req_valid && req_ready) || (rep_valid && rep_ready)) begin
                    state_d = SEND;
                    grant_d = rep_valid && rep_ready;
                    smac_d  = local_mac;
                    sip_d   = local_ip;
                    tmac_d  = grant_d ? rep_target_mac : 48'h0;
                    tip_d   = grant_d ? rep_target_ip : req_target_ip;
                end
            end
            SEND: begin
                if (tx.tx_ready) begin
                    stall_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (stall_q == STALL_LIM) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    stall_d = '0;
                    abort_d = 1'b1;
                end else begin
                    stall_d = stall_q + CNT_W'(1);
                end
            end
        endcase
    end

    assign opcode = grant_q ? 16'd2 : 16'd1;

    // Payload word selected by the current index.
    always_comb begin
        word = tip_q;
        case (idx_q)
            3'd0:    word = {HW_TYPE, PROTO_TYPE};
            3'd1:    word = {HW_LEN, PRO_LEN, opcode};
            3'd2:    word = smac_q[47:16];
            3'd3:    word = {smac_q[15:0], sip_q[31:16]};
            3'd4:    word = {sip_q[15:0], tmac_q[47:32]};
            3'd5:    word = tmac_q[31:0];
            default: word = tip_q;
        endcase
    end

    assign sending     = (state_q == SEND);
    assign tx.tx_valid = sending;
    assign tx.tx_last  = sending && (idx_q == LAST_IDX);
    assign tx.tx_data  = sending ? word : 32'h0;
    assign busy        = sending;
    assign grant_src   = grant_q;
    assign done        = done_q;
    assign abort       = abort_q;
endmodule
